arf_rat: RTL and testbench
==========================

// Module: arf_rat
// PURPOSE
//  Architectural register file plus rename/busy table, directly downstream of the ROB.
//  Dispatch writes the producer ROB id into the table. Register read returns the operand
//  source: {busy, rob_id, data}. busy=1 -> read the ROB at rob_id; busy=0 -> data is final.
//  ROB retire writes committed data and clears busy when the tag matches.
//  Redirect flush clears all speculative mappings.
// PARAMETERS
//  N_ARF     32  architectural registers; x0 hardwired zero
//  DATA_W    32  register data width (REG_DATA_WIDTH)
//  ROB_ID_W  3   ROB tag width, log2(ROB_N_ENTRIES)
// PORTS
//  clk                  in   1         clock; all state updates on the rising edge
//  rst_aL               in   1         reset: synchronous, active-low
//  dispatch_fire        in   1         dispatch handshake completed this cycle (valid & ready)
//  dispatch_dst_valid   in   1         dispatching instruction writes a register
//  dispatch_dst_arf_id  in   5         destination arch register
//  dispatch_rob_id      in   ROB_ID_W  ROB id allocated to the instruction
//  src1_arf_id          in   5         source 1 arch register
//  src1_busy            out  1         1: value pending in the ROB
//  src1_rob_id          out  ROB_ID_W  producer tag; valid when busy
//  src1_data            out  DATA_W    committed value; valid when !busy
//  src2_arf_id/busy/rob_id/data        same as src1
//  retire               in   1         ROB head commits this cycle
//  retire_rob_id        in   ROB_ID_W  tag of the retiring entry
//  retire_arf_id        in   5         destination of the retiring entry
//  retire_reg_data      in   DATA_W    committed value
//  fetch_redirect_valid in   1         flush: clear all busy bits
// BEHAVIOUR
//  State per reg r: data[r] (DATA_W), busy[r], tag[r] (ROB_ID_W). Reg 0 has no storage.
//  Reset (rst_aL==0 at the edge): all data=0, busy=0, tag=0. Reset overrides all other inputs.
//  Read ports are combinational, zero latency. Outputs follow their inputs and the state.
//  Read of src_arf_id==0: busy=0, rob_id=0, data=0.
//  Retire bypass: if retire && retire_arf_id==src && busy[src] && tag[src]==retire_rob_id,
//   the port shows busy=0, data=retire_reg_data in the same cycle.
//  No dispatch bypass: a source read in its own dispatch cycle sees the pre-dispatch mapping.
//  Retire edge: if retire and retire_arf_id!=0, data[a]<=retire_reg_data.
//   Also busy[a]<=0 if tag[a]==retire_rob_id. A stale tag leaves busy and tag unchanged.
//  Dispatch edge: if fire & dst_valid & dst!=0, busy[d]<=1 and tag[d]<=dispatch_rob_id.
//  Same reg, retire and dispatch in one cycle: data written, busy=1, tag=new rob id.
//   Dispatch wins for busy and tag.
//  Flush edge: all busy<=0, and any dispatch that cycle is dropped.
//   A retire write in the flush cycle still commits its data.
//  Flush and retire on different regs in one cycle: both data write and flush happen.
//  dst==0 and retire to 0 are ignored entirely.
//  Reset asserted mid-stream: next cycle all state is reset. The in-flight dispatch is lost.
//  Ordering: retire, then dispatch, then flush. Later stages override earlier ones for busy/tag.
// STRUCTURE
//  Shared package (global_defs): arf_id_t, rob_id_t, reg_data_t, ARF_N_ENTRIES, ROB_N_ENTRIES.
//   Add typedef arf_src_t {busy, rob_id, data}.
//  Sub-module arf_rat_rd_port: mux over the state plus retire bypass and x0 force.
//   Instantiated twice.
//  Per-register next-state logic lives in a generate loop. No separate FSM; the busy bits
//   are the state.
// TESTING
//  1 Reset, then read x5 and x0 -> busy=0, data=0 on both.
//  2 Dispatch x5 with rob 3, read x5 next cycle -> busy=1, rob_id=3.
//    Retire (rob 3, x5, 0xDEADBEEF) -> bypass shows busy=0, data=DEADBEEF that cycle and after.
//  3 Dispatch x7 with rob1, then rob4 (WAW). Retire rob1 with 0x11 -> data=0x11 written,
//    x7 still busy with tag 4. Retire rob4 with 0x22 -> busy=0, data=0x22.
//  4 Same cycle: retire (rob2, x9, 0xAA) and dispatch x9 with rob6 -> next cycle busy=1, tag 6.
//    A raw state check shows data=0xAA.
//  5 Make x3 and x4 busy, then assert flush with a dispatch of x8 in the same cycle.
//    -> x3, x4, x8 all busy=0, and the x3/x4 data is unchanged.
//  6 Dispatch with dst 0, retire to x0 with 0xFF, then assert rst_aL low mid-stream
//    -> x0 reads 0 with busy=0. After reset, all busy=0 and data=0.

Source files
------------

// File: rtl/arf_rat_pkg.sv
// -----------------------------------------------------------------------------
// arf_rat_pkg
//   Shared types and sizing for the architectural register file / rename table.
//   Every rtl/ file and the bench import this package.
//
//   ARF_N_ENTRIES  architectural registers (x0 hardwired to zero)
//   ROB_N_ENTRIES  ROB depth; ROB_ID_W = log2(ROB_N_ENTRIES)
//   DATA_W         register data width
//   arf_src_t      operand source as seen by a read port {busy, rob_id, data}
// -----------------------------------------------------------------------------
package arf_rat_pkg;

  localparam int ARF_N_ENTRIES = 32;
  localparam int ROB_N_ENTRIES = 8;
  localparam int DATA_W        = 32;
  localparam int ARF_ID_W      = $clog2(ARF_N_ENTRIES);
  localparam int ROB_ID_W      = $clog2(ROB_N_ENTRIES);

  typedef logic [ARF_ID_W-1:0] arf_id_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [DATA_W-1:0]   reg_data_t;

  // busy=1: operand is still in flight, fetch it from the ROB at rob_id.
  // busy=0: data holds the committed value.
  typedef struct packed {
    logic      busy;
    rob_id_t   rob_id;
    reg_data_t data;
  } arf_src_t;

  localparam arf_src_t SRC_ZERO = '0;

  // x0 has no storage; every path that touches a register checks this first.
  function automatic logic is_x0(arf_id_t id);
    return id == '0;
  endfunction

endpackage

// File: rtl/arf_rat_if.sv
// -----------------------------------------------------------------------------
// arf_rat_if
//   Bundles the dispatch, retire, flush and two read-port signals of the
//   register file / rename table.
//
//   modport master : pipeline side (dispatch/ROB/fetch), drives requests and
//                    source ids, receives operand sources
//   modport slave  : the arf_rat itself
//
//   dispatch_fire/dst_valid/dst_arf_id/rob_id  producer mapping request
//   srcN_arf_id -> srcN_busy/rob_id/data        combinational operand lookup
//   retire/retire_rob_id/arf_id/reg_data        ROB head commit
//   fetch_redirect_valid                        flush of speculative mappings
// -----------------------------------------------------------------------------
interface arf_rat_if;
  import arf_rat_pkg::*;

  logic      dispatch_fire;
  logic      dispatch_dst_valid;
  arf_id_t   dispatch_dst_arf_id;
  rob_id_t   dispatch_rob_id;

  arf_id_t   src1_arf_id;
  logic      src1_busy;
  rob_id_t   src1_rob_id;
  reg_data_t src1_data;

  arf_id_t   src2_arf_id;
  logic      src2_busy;
  rob_id_t   src2_rob_id;
  reg_data_t src2_data;

  logic      retire;
  rob_id_t   retire_rob_id;
  arf_id_t   retire_arf_id;
  reg_data_t retire_reg_data;

  logic      fetch_redirect_valid;

  modport master (
    output dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
    output src1_arf_id, src2_arf_id,
    input  src1_busy, src1_rob_id, src1_data,
    input  src2_busy, src2_rob_id, src2_data,
    output retire, retire_rob_id, retire_arf_id, retire_reg_data,
    output fetch_redirect_valid
  );

  modport slave (
    input  dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
    input  src1_arf_id, src2_arf_id,
    output src1_busy, src1_rob_id, src1_data,
    output src2_busy, src2_rob_id, src2_data,
    input  retire, retire_rob_id, retire_arf_id, retire_reg_data,
    input  fetch_redirect_valid
  );

endinterface

// File: rtl/arf_rat_rd_port.sv
// -----------------------------------------------------------------------------
// arf_rat_rd_port
//   One combinational operand read port: selects the register state for
//   i_arf_id, applies the same-cycle retire bypass and forces x0 to zero.
//
//   i_arf_id           register to read
//   i_busy_vec         busy bit per register (entry 0 tied low)
//   i_tag_vec          producer ROB tag per register
//   i_data_vec         committed data per register (entry 0 tied to zero)
//   i_retire*          retire request of this cycle, for the bypass
//   o_src              {busy, rob_id, data} seen by the consumer
// -----------------------------------------------------------------------------
module arf_rat_rd_port
  import arf_rat_pkg::*;
(
  input  arf_id_t                        i_arf_id,
  input  logic    [ARF_N_ENTRIES-1:0]    i_busy_vec,
  input  rob_id_t [ARF_N_ENTRIES-1:0]    i_tag_vec,
  input  reg_data_t [ARF_N_ENTRIES-1:0]  i_data_vec,
  input  logic                           i_retire,
  input  rob_id_t                        i_retire_rob_id,
  input  arf_id_t                        i_retire_arf_id,
  input  reg_data_t                      i_retire_reg_data,
  output arf_src_t                       o_src
);

  logic      w_busy;
  rob_id_t   w_tag;
  reg_data_t w_data;
  logic      w_bypass;

  assign w_busy = i_busy_vec[i_arf_id];
  assign w_tag  = i_tag_vec[i_arf_id];
  assign w_data = i_data_vec[i_arf_id];

  // The producer is committing right now: hand the consumer the final value
  // instead of making it chase a ROB entry that is about to be freed.
  // A stale retire (older tag than the current mapping) must not bypass.
  assign w_bypass = i_retire && (i_retire_arf_id == i_arf_id) &&
                    w_busy && (w_tag == i_retire_rob_id);

  // NOTE: every output of a combinational block gets a default on entry so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    o_src = SRC_ZERO;
    if (!is_x0(i_arf_id)) begin
      o_src.busy   = w_busy && !w_bypass;
      o_src.rob_id = w_tag;
      o_src.data   = w_bypass ? i_retire_reg_data : w_data;
    end
  end

endmodule

// File: rtl/arf_rat.sv
// -----------------------------------------------------------------------------
// arf_rat
//   Architectural register file plus rename/busy table, sitting directly
//   downstream of the ROB.
//     - Dispatch records the producer ROB id of a destination register and
//       marks it busy.
//     - Two combinational read ports return {busy, rob_id, data}; a retire in
//       the same cycle is bypassed onto a matching read.
//     - Retire writes committed data and clears busy only when the retiring
//       tag is still the current mapping.
//     - A fetch redirect clears every busy bit and drops that cycle's dispatch.
//   Per cycle the updates apply as retire, then dispatch, then flush; later
//   ones override earlier ones for busy/tag. x0 has no storage.
//
//   clk     rising-edge clock
//   rst_aL  synchronous active-low reset; clears data, busy and tag
//   rat     arf_rat_if.slave bundle (dispatch, read ports, retire, flush)
// -----------------------------------------------------------------------------
module arf_rat
  import arf_rat_pkg::*;
(
  input  logic     clk,
  input  logic     rst_aL,
  arf_rat_if.slave rat
);

  logic      [ARF_N_ENTRIES-1:0] w_busy_vec;
  rob_id_t   [ARF_N_ENTRIES-1:0] w_tag_vec;
  reg_data_t [ARF_N_ENTRIES-1:0] w_data_vec;

  logic      w_dispatch_en;
  arf_src_t  w_src1;
  arf_src_t  w_src2;

  // x0 reads as a non-busy zero; its slot in the vectors is a constant.
  assign w_busy_vec[0] = 1'b0;
  assign w_tag_vec[0]  = '0;
  assign w_data_vec[0] = '0;

  assign w_dispatch_en = rat.dispatch_fire && rat.dispatch_dst_valid;

  // ---------------------------------------------------------------------------
  // Per-register state. The busy bits are the only control state; there is
  // no separate FSM.
  // ---------------------------------------------------------------------------
  for (genvar g = 1; g < ARF_N_ENTRIES; g++) begin : g_reg
    logic      r_busy;
    rob_id_t   r_tag;
    reg_data_t r_data;
    logic      w_ret_hit;
    logic      w_disp_hit;

    assign w_ret_hit  = rat.retire && (rat.retire_arf_id == arf_id_t'(g));
    assign w_disp_hit = w_dispatch_en && (rat.dispatch_dst_arf_id == arf_id_t'(g));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
      if (!rst_aL) begin
        // NOTE: the data array is reset too, since a read after reset must
        // return zero for every register, not whatever the storage powered up to.
        r_busy <= 1'b0;
        r_tag  <= '0;
        r_data <= '0;
      end else begin
        // NOTE: retire, dispatch and flush are written in priority order; the
        // last non-blocking assignment to r_busy/r_tag in the block wins.
        if (w_ret_hit) begin
          r_data <= rat.retire_reg_data;
          // A retire of an older producer (WAW) only commits data; the
          // newer mapping keeps the register busy.
          if (r_tag == rat.retire_rob_id) begin
            r_busy <= 1'b0;
          end
        end
        if (w_disp_hit) begin
          r_busy <= 1'b1;
          r_tag  <= rat.dispatch_rob_id;
        end
        // The flush also cancels this cycle's dispatch; tags are left as-is
        // because busy=0 makes them meaningless.
        if (rat.fetch_redirect_valid) begin
          r_busy <= 1'b0;
        end
      end
    end

    assign w_busy_vec[g] = r_busy;
    assign w_tag_vec[g]  = r_tag;
    assign w_data_vec[g] = r_data;
  end

  // ---------------------------------------------------------------------------
  // Read ports. They see the pre-edge mapping, so a source read in its own
  // dispatch cycle gets the previous producer, not the one being dispatched.
  // ---------------------------------------------------------------------------
  arf_rat_rd_port u_rd_port1 (
    .i_arf_id          (rat.src1_arf_id),
    .i_busy_vec        (w_busy_vec),
    .i_tag_vec         (w_tag_vec),
    .i_data_vec        (w_data_vec),
    .i_retire          (rat.retire),
    .i_retire_rob_id   (rat.retire_rob_id),
    .i_retire_arf_id   (rat.retire_arf_id),
    .i_retire_reg_data (rat.retire_reg_data),
    .o_src             (w_src1)
  );

  arf_rat_rd_port u_rd_port2 (
    .i_arf_id          (rat.src2_arf_id),
    .i_busy_vec        (w_busy_vec),
    .i_tag_vec         (w_tag_vec),
    .i_data_vec        (w_data_vec),
    .i_retire          (rat.retire),
    .i_retire_rob_id   (rat.retire_rob_id),
    .i_retire_arf_id   (rat.retire_arf_id),
    .i_retire_reg_data (rat.retire_reg_data),
    .o_src             (w_src2)
  );

  assign rat.src1_busy   = w_src1.busy;
  assign rat.src1_rob_id = w_src1.rob_id;
  assign rat.src1_data   = w_src1.data;
  assign rat.src2_busy   = w_src2.busy;
  assign rat.src2_rob_id = w_src2.rob_id;
  assign rat.src2_data   = w_src2.data;

endmodule

// File: tb/tb_arf_rat.sv
// -----------------------------------------------------------------------------
// tb_arf_rat
//   Directed, table-driven bench for arf_rat. Each table row is one clock
//   cycle: the inputs are applied after a rising edge, both read ports are
//   compared at the following falling edge (so same-cycle bypass is visible
//   and the pre-dispatch mapping is observed), then the next rising edge
//   commits the row. Reset mid-stream and x0 handling are hand-written.
// -----------------------------------------------------------------------------
module tb_arf_rat;
  import arf_rat_pkg::*;

  logic clk = 1'b0;
  logic rst_aL;

  arf_rat_if u_if ();

  arf_rat u_dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .rat    (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string     name;
    int        rst_n;
    int        disp;  int dst;  int drob;
    int        ret;   int rrob; int rarf; int rdata;
    int        flush;
    int        s1;    arf_src_t e1; int f1;
    int        s2;    arf_src_t e2; int f2;
  } vec_t;

  vec_t vecs[$];

  function automatic arf_src_t src(int b, int t, int d);
    arf_src_t s;
    s.busy   = (b != 0);
    s.rob_id = rob_id_t'(t);
    s.data   = reg_data_t'(d);
    return s;
  endfunction

  // f=1 compares every field; otherwise rob_id is compared only when busy is
  // expected and data only when not busy.
  function automatic vec_t mk(string n, int rst_n,
                              int disp, int dst, int drob,
                              int ret, int rrob, int rarf, int rdata, int flush,
                              int s1, int b1, int t1, int d1, int f1,
                              int s2, int b2, int t2, int d2, int f2);
    vec_t v;
    v.name = n; v.rst_n = rst_n;
    v.disp = disp; v.dst = dst; v.drob = drob;
    v.ret = ret; v.rrob = rrob; v.rarf = rarf; v.rdata = rdata;
    v.flush = flush;
    v.s1 = s1; v.e1 = src(b1, t1, d1); v.f1 = f1;
    v.s2 = s2; v.e2 = src(b2, t2, d2); v.f2 = f2;
    return v;
  endfunction

  task automatic drive(int rst_n, int fire, int dv, int dst, int drob,
                       int ret, int rrob, int rarf, int rdata, int flush,
                       int s1, int s2);
    rst_aL                     = (rst_n != 0);
    u_if.dispatch_fire         = (fire != 0);
    u_if.dispatch_dst_valid    = (dv != 0);
    u_if.dispatch_dst_arf_id   = arf_id_t'(dst);
    u_if.dispatch_rob_id       = rob_id_t'(drob);
    u_if.retire                = (ret != 0);
    u_if.retire_rob_id         = rob_id_t'(rrob);
    u_if.retire_arf_id         = arf_id_t'(rarf);
    u_if.retire_reg_data       = reg_data_t'(rdata);
    u_if.fetch_redirect_valid  = (flush != 0);
    u_if.src1_arf_id           = arf_id_t'(s1);
    u_if.src2_arf_id           = arf_id_t'(s2);
  endtask

  task automatic check(string name, arf_src_t got, arf_src_t exp, int full);
    logic ok;
    n_checks++;
    if (full != 0)    ok = (got == exp);
    else if (exp.busy) ok = got.busy && (got.rob_id == exp.rob_id);
    else               ok = !got.busy && (got.data == exp.data);
    if (ok) n_pass++;
    else $display("FAIL %s: got busy=%0b rob_id=%0d data=%h, expected busy=%0b rob_id=%0d data=%h",
                  name, got.busy, got.rob_id, got.data, exp.busy, exp.rob_id, exp.data);
  endtask

  function automatic arf_src_t port1();
    arf_src_t s;
    s.busy = u_if.src1_busy; s.rob_id = u_if.src1_rob_id; s.data = u_if.src1_data;
    return s;
  endfunction

  function automatic arf_src_t port2();
    arf_src_t s;
    s.busy = u_if.src2_busy; s.rob_id = u_if.src2_rob_id; s.data = u_if.src2_data;
    return s;
  endfunction

  // Advance to the next rising edge and step off it before driving again.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              name             rst dsp dst rob ret rrb rarf rdata        fl  s1 b1 t1 d1            f1  s2 b2 t2 d2            f2
    vecs.push_back(mk("reset_rd",      1, 0, 0, 0,  0, 0, 0,  0,            0,  5, 0, 0, 0,            1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("disp_x5_nobyp", 1, 1, 5, 3,  0, 0, 0,  0,            0,  5, 0, 0, 0,            1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("x5_busy",       1, 0, 0, 0,  0, 0, 0,  0,            0,  5, 1, 3, 0,            1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("x5_ret_byp",    1, 0, 0, 0,  1, 3, 5,  32'hDEADBEEF, 0,  5, 0, 3, 32'hDEADBEEF, 1,  5, 0, 3, 32'hDEADBEEF, 1));
    vecs.push_back(mk("x5_committed",  1, 0, 0, 0,  0, 0, 0,  0,            0,  5, 0, 3, 32'hDEADBEEF, 1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("waw_disp1",     1, 1, 7, 1,  0, 0, 0,  0,            0,  7, 0, 0, 0,            1,  5, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("waw_disp4",     1, 1, 7, 4,  0, 0, 0,  0,            0,  7, 1, 1, 0,            1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("waw_stale_ret", 1, 0, 0, 0,  1, 1, 7,  32'h11,       0,  7, 1, 4, 0,            1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("waw_still_bsy", 1, 0, 0, 0,  0, 0, 0,  0,            0,  7, 1, 4, 32'h11,       1,  5, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("waw_ret4_byp",  1, 0, 0, 0,  1, 4, 7,  32'h22,       0,  7, 0, 4, 32'h22,       1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("waw_done",      1, 0, 0, 0,  0, 0, 0,  0,            0,  7, 0, 4, 32'h22,       1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("x9_disp2",      1, 1, 9, 2,  0, 0, 0,  0,            0,  9, 0, 0, 0,            1,  7, 0, 0, 32'h22,       0));
    vecs.push_back(mk("x9_ret_disp",   1, 1, 9, 6,  1, 2, 9,  32'hAA,       0,  9, 0, 2, 32'hAA,       1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("x9_disp_wins",  1, 0, 0, 0,  0, 0, 0,  0,            0,  9, 1, 6, 32'hAA,       1,  0, 0, 0, 0,            1));
    vecs.push_back(mk("x3_wr_x4_disp", 1, 1, 4, 5,  1, 0, 3,  32'h33,       0,  3, 0, 0, 0,            1,  4, 0, 0, 0,            1));
    vecs.push_back(mk("x4_wr_x3_disp", 1, 1, 3, 7,  1, 0, 4,  32'h44,       0,  4, 1, 5, 0,            1,  3, 0, 0, 32'h33,       1));
    vecs.push_back(mk("flush_disp_x8", 1, 1, 8, 2,  0, 0, 0,  0,            1,  3, 1, 7, 32'h33,       1,  4, 1, 5, 32'h44,       1));
    vecs.push_back(mk("flush_x3_x4",   1, 0, 0, 0,  0, 0, 0,  0,            0,  3, 0, 0, 32'h33,       0,  4, 0, 0, 32'h44,       0));
    vecs.push_back(mk("flush_x8_x9",   1, 0, 0, 0,  0, 0, 0,  0,            0,  8, 0, 0, 0,            0,  9, 0, 0, 32'hAA,       0));
    vecs.push_back(mk("x12_disp1",     1, 1, 12, 1, 0, 0, 0,  0,            0, 12, 0, 0, 0,            1, 13, 0, 0, 0,            1));
    vecs.push_back(mk("flush_ret_x13", 1, 0, 0, 0,  1, 2, 13, 32'h5A,       1, 12, 1, 1, 0,            1, 13, 0, 0, 0,            1));
    vecs.push_back(mk("flush_ret_aft", 1, 0, 0, 0,  0, 0, 0,  0,            0, 12, 0, 0, 0,            0, 13, 0, 0, 32'h5A,       1));

    // Reset for two edges with every request idle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].disp, vecs[i].disp, vecs[i].dst, vecs[i].drob,
            vecs[i].ret, vecs[i].rrob, vecs[i].rarf, vecs[i].rdata, vecs[i].flush,
            vecs[i].s1, vecs[i].s2);
      @(negedge clk);
      check({vecs[i].name, ".src1"}, port1(), vecs[i].e1, vecs[i].f1);
      check({vecs[i].name, ".src2"}, port2(), vecs[i].e2, vecs[i].f2);
      next_cycle();
    end

    // x0: dispatch to x0 and retire to x0 with a bypass-shaped request.
    drive(1, 1, 1, 0, 4, 1, 4, 0, 32'hFF, 0, 0, 0);
    @(negedge clk);
    check("x0_byp.src1", port1(), src(0, 0, 0), 1);
    check("x0_byp.src2", port2(), src(0, 0, 0), 1);
    next_cycle();

    // Fire without a destination must not touch the table.
    drive(1, 1, 0, 5, 2, 0, 0, 0, 0, 0, 0, 5);
    @(negedge clk);
    check("x0_after", port1(), src(0, 0, 0), 1);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    check("no_dst_valid.x5", port1(), src(0, 3, 32'hDEADBEEF), 1);
    check("no_dst_valid.x0", port2(), src(0, 0, 0), 1);
    next_cycle();

    // Reset mid-stream with a dispatch and a retire in flight: both are lost.
    drive(0, 1, 1, 5, 6, 1, 4, 7, 32'h99, 0, 7, 9);
    @(negedge clk);
    check("pre_rst.x7", port1(), src(0, 4, 32'h22), 1);
    check("pre_rst.x9", port2(), src(0, 0, 32'hAA), 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    @(negedge clk);
    check("rst_lost_disp.x5", port1(), src(0, 0, 0), 1);
    check("rst_lost_ret.x7",  port2(), src(0, 0, 0), 1);
    next_cycle();

    for (int r = 0; r < ARF_N_ENTRIES; r += 2) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, r + 1);
      @(negedge clk);
      check($sformatf("rst_all.x%0d", r),     port1(), src(0, 0, 0), 1);
      check($sformatf("rst_all.x%0d", r + 1), port2(), src(0, 0, 0), 1);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
